// File: rtl/eager_fork_register_block.sv
`default_nettype none
// ============================================================================
// Module   : eager_fork_register_block
// Purpose  : Per-output pending bit and valid/stall generation for eager_fork.
// Revision : 1.0 - initial release
// ============================================================================
module eager_fork_register_block (
    input  logic clk,
    input  logic rst,
    input  logic ins_valid,
    input  logic outs_ready,
    input  logic any_stall,
    output logic outs_valid,
    output logic stall
);

    logic r_pending;
    logic w_valid;
    logic w_stall;

    assign w_valid    = ins_valid & r_pending;
    assign w_stall    = w_valid & ~outs_ready;
    assign outs_valid = w_valid;
    assign stall      = w_stall;

    // With no stall anywhere the token is done (or absent), so re-arm; otherwise
    // remember only whether this output still owes a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b1;
        end else if (!any_stall) begin
            r_pending <= 1'b1;
        end else begin
            r_pending <= w_stall;
        end
    end

endmodule
`default_nettype wire

// File: rtl/eager_fork.sv
`default_nettype none
// ============================================================================
// Module   : eager_fork
// Purpose  : One-to-many handshake fork; each output accepts the token once,
//            the input is released when all outputs have taken it.
// Revision : 1.0 - initial release
// ============================================================================
module eager_fork #(
    parameter int SIZE      = 2,
    parameter int DATA_TYPE = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_TYPE-1:0]      ins,
    input  logic                      ins_valid,
    output logic                      ins_ready,
    output logic [SIZE*DATA_TYPE-1:0] outs,
    output logic [SIZE-1:0]           outs_valid,
    input  logic [SIZE-1:0]           outs_ready
);

    logic [SIZE-1:0] w_stall;
    logic            w_any_stall;

    assign w_any_stall = |w_stall;
    assign ins_ready   = ~w_any_stall;
    assign outs        = {SIZE{ins}};

    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_out
            eager_fork_register_block u_reg (
                .clk        (clk),
                .rst        (rst),
                .ins_valid  (ins_valid),
                .outs_ready (outs_ready[gi]),
                .any_stall  (w_any_stall),
                .outs_valid (outs_valid[gi]),
                .stall      (w_stall[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/eager_fork.md
Name: eager_fork

Overview:
- One-to-many handshake fork for the dataflow circuit library: one producer is broadcast to SIZE consumers.
- Each output is served independently, so a consumer may accept the token in an earlier cycle than the others.
- The input is released only after every output has taken the current token.
- Counterpart of the many-to-one join; placed wherever one SSA value feeds multiple consumers.

Parameters:
- SIZE, 2, number of outputs (at least 1).
- DATA_TYPE, 32, payload width in bits (at least 1). The dataless variant is DATA_TYPE=1 with the payload tied 0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- ins  input  DATA_TYPE  input payload.
- ins_valid  input  1  input token valid.
- ins_ready  output  1  input token accepted this cycle.
- outs  output  SIZE*DATA_TYPE  slice i = bits [i*DATA_TYPE +: DATA_TYPE]; every slice equals ins.
- outs_valid  output  SIZE  per-output valid.
- outs_ready  input  SIZE  per-output ready.

Behaviour:
- State: one bit per output, pending[i]. pending[i]=1 means output i has not yet taken the current token.
- Reset: on a clk edge with rst=1, pending = all ones.
  - Outputs are combinational, so during reset outs_valid = ins_valid replicated.
  - Environment must hold ins_valid=0 while rst=1.
- Combinational outputs:
  - outs[i] = ins.
  - outs_valid[i] = ins_valid & pending[i].
  - stall[i] = outs_valid[i] & ~outs_ready[i].
  - any_stall = OR of stall.
  - ins_ready = ~any_stall.
- Latency: zero cycles, valid to valid and ready to ready. No payload register; this is a pure handshake block with per-output memory.
- Register update on each clk edge with rst=0:
  - If any_stall=0, pending <= all ones. This covers two cases: the token completed, or no token was present.
  - Else pending[i] <= stall[i]. Outputs that already transferred are cleared; outputs still stalled stay set.
- Transfer on output i occurs when outs_valid[i] & outs_ready[i].
  - Each output transfers exactly once per input token.
  - An output with pending[i]=0 never asserts valid again for the same token.
- Simultaneous events:
  - All outputs ready in the same cycle: the token completes in that cycle and ins_ready=1.
  - Last stalled output becomes ready: ins_ready=1 that cycle, and the next token may be presented the following cycle with pending all ones.
- ins_valid dropping mid-token is a protocol violation and is not required to be handled. Observable result: any_stall=0, so pending resets to all ones.
- Protocol requirement on the producer: ins and ins_valid are held stable until ins_ready=1.
- Reset mid-token: pending returns to all ones and partially delivered outputs are forgotten. The upstream is assumed reset in the same cycle.
- SIZE=1: degenerates to a wire. ins_ready = outs_ready[0] | ~ins_valid; pending stays 1.
- Combinational paths outs_ready to ins_ready and ins_valid to outs_valid are intentional. Buffers break them elsewhere.

Decomposition:
- No shared package is needed. The block uses no typedefs or encodings; SIZE and DATA_TYPE are plain parameters.
- Natural sub-module: eager_fork_register_block, one instance per output.
  - Inputs: clk, rst, ins_valid, outs_ready[i], any_stall.
  - Outputs: outs_valid[i], stall[i].
  - Holds pending[i].
- Top level: generate loop of instances, OR-reduction for any_stall, and payload replication.

Test Plan (SIZE=3, DATA_TYPE=8):
- Reset: rst=1 for 2 cycles with ins_valid=0, then ins_valid=1, ins=0x5A, outs_ready=3'b111.
  - Same cycle: outs_valid=3'b111, all outs slices 0x5A, ins_ready=1.
- Staggered accept: ins=0x11 valid.
  - Cycle 0, outs_ready=3'b001: outs_valid=3'b111, ins_ready=0.
  - Cycle 1, outs_ready=3'b000: outs_valid=3'b110, ins_ready=0.
  - Cycle 2, outs_ready=3'b110: outs_valid=3'b110, ins_ready=1.
  - Cycle 3, new token 0x22: outs_valid=3'b111.
  - Check each output transfers 0x11 exactly once.
- Back-to-back tokens 0x01..0x08 with outs_ready=3'b111: ins_ready=1 every cycle; each output receives 8 tokens in order.
- Random per-output ready at 30% probability, 500 tokens: scoreboard per output sees the identical sequence; no duplicates and no drops.
- Reset mid-token: after a token of 0xAA is accepted on output 0 only, assert rst for one cycle.
  - Next cycle: pending=3'b111, and with ins_valid=1 outs_valid=3'b111.
- Idle: ins_valid=0 for 10 cycles with arbitrary outs_ready.
  - outs_valid=0 and ins_ready=1 throughout; pending stays all ones.
